// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding
// and the default operand width.
package serial_adder_ctrl_pkg;

  localparam int SAC_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_fa_bit.sv
// One-bit full-adder cell shared by every bit position of the serial adder.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: drives one fa_bit for WIDTH cycles, LSB first,
// recirculating the carry, then presents sum/co with a one-cycle done pulse.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = SAC_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] w_sum_shift;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             w_s;
  logic             w_co;
  logic             w_load;
  logic             w_last;

  fa_bit u_fa (
    .a  (r_a[0]),
    .b  (r_b[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  always_comb begin
    w_last = (r_cnt == CW'(WIDTH - 1));
    w_load = 1'b0;
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Written as shift-then-overwrite-MSB so WIDTH=1 needs no special slice.
  always_comb begin
    w_sum_shift            = r_sum >> 1;
    w_sum_shift[WIDTH-1]   = w_s;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_a     <= a;
      r_b     <= b;
      r_sum   <= '0;
      r_carry <= ci_in;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_sum   <= w_sum_shift;
      r_carry <= w_co;
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign co   = r_carry;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH 8, 4 and 1: drivers push
// expected results, per-instance monitors pop and compare on done.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int nchk  = 0;
  int npass = 0;
  bit fin [3];

  task automatic chk(input string nm, input int w, input logic [63:0] act,
                     input logic [63:0] expv);
    nchk++;
    if (act === expv) npass++;
    else $display("FAIL %s (W=%0d, edge %0d): got %0h expected %0h",
                  nm, w, edge_n, act, expv);
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g
    localparam int W = (gi == 0) ? 8 : (gi == 1) ? 4 : 1;

    logic         rst, start, ci_in, busy, done, co;
    logic [W-1:0] a, b, sum;

    serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .ci_in (ci_in),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .co    (co)
    );

    typedef struct packed {
      logic [W:0]  res;
      logic [31:0] acc;
    } ent_t;

    ent_t       q[$];
    logic [W:0] hold;
    bit         mon_en = 1'b0;
    logic       prev_done = 1'b0;

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, y,
                                           input logic c);
      longint t;
      t = longint'(x) + longint'(y) + longint'(c);
      return t[W:0];
    endfunction

    task automatic step();
      @(posedge clk);
      #1;
    endtask

    // Called just after edge n; request is accepted at edge n+1.
    task automatic kick(input logic [W-1:0] x, y, input logic c);
      a = x; b = y; ci_in = c; start = 1'b1;
      q.push_back('{res: ref_add(x, y, c), acc: edge_n + 1});
    endtask

    task automatic op(input logic [W-1:0] x, y, input logic c);
      step();
      kick(x, y, c);
      step();
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); ci_in = 1'($urandom);
      repeat (W) step();
    endtask

    always @(negedge clk) begin
      if (mon_en) begin
        logic exp_busy;
        ent_t e;
        exp_busy = (q.size() > 0) && (edge_n >= q[0].acc) &&
                   (edge_n < q[0].acc + W);
        chk("busy", W, busy, exp_busy);
        chk("done_gap", W, prev_done & done, 0);
        prev_done = done;
        if (done) begin
          if (q.size() == 0) begin
            chk("unexpected_done", W, 1, 0);
          end else begin
            e = q.pop_front();
            chk("latency", W, edge_n, e.acc + W);
            chk("sum_co", W, {co, sum}, e.res);
            hold = e.res;
          end
        end else if (!busy) begin
          chk("held", W, {co, sum}, hold);
        end
      end
    end

    initial begin
      rst = 1'b1; start = 1'b0; a = '0; b = '0; ci_in = 1'b0; hold = '0;
      repeat (2) step();
      rst = 1'b0;
      mon_en = 1'b1;

      // reset in the middle of a run, then a normal addition
      step();
      kick(W'(8'h12), W'(8'h34), 1'b0);
      step();
      start = 1'b0;
      repeat (2) step();
      rst = 1'b1;
      step();
      q.delete();
      hold = '0;
      rst = 1'b0;
      op(W'(8'h12), W'(8'h34), 1'b0);

      op(W'(8'hFF), W'(8'h01), 1'b0);
      op(W'(8'h0F), W'(8'h10), 1'b1);
      op(W'(8'h80), W'(8'h7F), 1'b1);

      // start pulses while running must be ignored
      step();
      kick(W'(8'h5A), W'(8'hC3), 1'b1);
      step();
      for (int unsigned j = 1; j <= W; j++) begin
        start = (j == 2 || j == 5 || j == W);
        a = W'($urandom); b = W'($urandom); ci_in = 1'($urandom);
        step();
      end
      start = 1'b0;

      // back-to-back with start held high
      step();
      kick(W'(3), W'(5), 1'b0);
      step();
      a = W'(200); b = W'(100); ci_in = 1'b0;
      q.push_back('{res: ref_add(W'(200), W'(100), 1'b0), acc: edge_n + W + 1});
      repeat (W + 1) step();
      start = 1'b0;
      repeat (W) step();

      if (W <= 4) begin
        for (int unsigned x = 0; x < (1 << W); x++)
          for (int unsigned y = 0; y < (1 << W); y++)
            for (int unsigned c = 0; c < 2; c++)
              op(W'(x), W'(y), 1'(c));
      end else begin
        for (int unsigned n = 0; n < 200; n++)
          op(W'($urandom), W'($urandom), 1'($urandom));
      end

      repeat (3) step();
      chk("drain", W, q.size(), 0);
      fin[gi] = 1'b1;
    end
  end

  initial begin
    bit timed_out;
    timed_out = 1'b0;
    fork
      wait (fin[0] && fin[1] && fin[2]);
      begin
        #500000;
        timed_out = 1'b1;
      end
    join_any
    disable fork;
    chk("timeout", 0, timed_out, 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
